// File: rtl/imem_stream_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory stream loader.
package imem_stream_loader_pkg;

  localparam int unsigned BytesPerWord = 4;
  localparam int unsigned CountWidth   = 16;

  typedef enum logic [2:0] {
    StCntLo,
    StCntHi,
    StWord,
    StSum,
    StDone,
    StErr
  } state_e;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_stream_loader_if #(
  parameter int unsigned ADDR_WIDTH = 6
);
  logic                  in_valid;
  logic [7:0]            in_data;
  logic                  in_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_stream_loader_byte_word_packer.sv
// Assembles little-endian bytes into words; pulses word_done the cycle after the last byte.
module byte_word_packer
  import imem_stream_loader_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [7:0]            data,
  output logic                  last,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_done
);

  localparam int unsigned IdxWidth = $clog2(BytesPerWord);
  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(BytesPerWord - 1);

  logic [IdxWidth-1:0]   idx_q;
  logic [WORD_WIDTH-9:0] lanes_q;
  logic [WORD_WIDTH-1:0] word_q;
  logic                  done_q;

  assign last      = (idx_q == LastIdx);
  assign word      = word_q;
  assign word_done = done_q;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      idx_q   <= '0;
      lanes_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (push) begin
        if (last) begin
          word_q <= {data, lanes_q};
          idx_q  <= '0;
          done_q <= 1'b1;
        end else begin
          // Earlier bytes shift down so byte 0 ends up in the low lane.
          lanes_q <= {data, lanes_q[WORD_WIDTH-9:8]};
          idx_q   <= idx_q + IdxWidth'(1);
        end
      end
    end
  end

endmodule

// File: rtl/imem_stream_loader.sv
// Loads a counted, XOR-checksummed byte stream into instruction memory; holds the core in reset.
module imem_stream_loader
  import imem_stream_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  imem_stream_loader_if.slave  bus,
  input  logic                 reload,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam logic [CountWidth-1:0] DepthCount = CountWidth'(Depth);
  localparam logic [ADDR_WIDTH:0]   One        = (ADDR_WIDTH + 1)'(1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [7:0]            xsum_q, xsum_d;
  logic [ADDR_WIDTH:0]   total_q, total_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [CountWidth-1:0] count;
  logic                  fire;
  logic                  restart;
  logic                  pk_last;
  logic                  word_done;
  logic [WORD_WIDTH-1:0] word;

  assign fire    = bus.in_valid & bus.in_ready;
  assign restart = reload & ((state_q == StDone) | (state_q == StErr));
  assign count   = {bus.in_data, cnt_lo_q};

  byte_word_packer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_packer (
    .clock    (clock),
    .reset    (reset),
    .clear    (restart),
    .push     (fire & (state_q == StWord)),
    .data     (bus.in_data),
    .last     (pk_last),
    .word     (word),
    .word_done(word_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_lo_d = cnt_lo_q;
    xsum_d   = xsum_q;
    total_d  = total_q;
    wcnt_d   = wcnt_q;
    if (word_done) begin
      wcnt_d = wcnt_q + One;
    end
    unique case (state_q)
      StCntLo: begin
        if (fire) begin
          cnt_lo_d = bus.in_data;
          xsum_d   = xsum_q ^ bus.in_data;
          state_d  = StCntHi;
        end
      end
      StCntHi: begin
        if (fire) begin
          xsum_d = xsum_q ^ bus.in_data;
          if (count == '0) begin
            state_d = StSum;
          end else if (count > DepthCount) begin
            state_d = StErr;
          end else begin
            total_d = count[ADDR_WIDTH:0];
            state_d = StWord;
          end
        end
      end
      StWord: begin
        if (fire) begin
          xsum_d = xsum_q ^ bus.in_data;
          // The previous word's counter increment has always landed by this byte.
          if (pk_last && (wcnt_q == total_q - One)) begin
            state_d = StSum;
          end
        end
      end
      StSum: begin
        if (fire) begin
          state_d = (bus.in_data == xsum_q) ? StDone : StErr;
        end
      end
      StDone, StErr: begin
        if (reload) begin
          state_d  = StCntLo;
          cnt_lo_d = '0;
          xsum_d   = '0;
          total_d  = '0;
          wcnt_d   = '0;
        end
      end
      default: state_d = StCntLo;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StCntLo;
      cnt_lo_q <= '0;
      xsum_q   <= '0;
      total_q  <= '0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_lo_q <= cnt_lo_d;
      xsum_q   <= xsum_d;
      total_q  <= total_d;
      wcnt_q   <= wcnt_d;
    end
  end

  assign bus.in_ready   = (state_q == StCntLo) | (state_q == StCntHi) |
                          (state_q == StWord)  | (state_q == StSum);
  assign bus.imem_we    = word_done;
  assign bus.imem_addr  = wcnt_q[ADDR_WIDTH-1:0];
  assign bus.imem_wdata = word;
  assign done           = (state_q == StDone);
  assign error          = (state_q == StErr);
  assign cpu_reset      = (state_q != StDone);

endmodule

// File: tb/tb_imem_stream_loader.sv
// Self-checking bench for imem_stream_loader: frame table plus hand-written corner sequences.
module tb_imem_stream_loader;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic reload = 1'b0;
  logic cpu_reset, done, error;

  imem_stream_loader_if #(.ADDR_WIDTH(6)) bus ();

  imem_stream_loader #(
    .ADDR_WIDTH(6),
    .WORD_WIDTH(32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .reload   (reload),
    .cpu_reset(cpu_reset),
    .done     (done),
    .error    (error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  typedef struct {
    int n;
    bit fixed;
    bit bad;
    int gapmax;
    bit exp_done;
    bit exp_error;
    int exp_writes;
  } vec_t;

  wr_t         exp_q[$];
  logic [31:0] words[64];
  vec_t        vecs[5];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_count = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every observed write must match the oldest expected write.
  always @(negedge clock) begin
    if (bus.imem_we === 1'b1) begin
      wr_t e;
      wr_count++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.imem_addr, bus.imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {26'b0, bus.imem_addr}, {26'b0, e.addr});
        check("wr_data", bus.imem_wdata, e.data);
        check("wr_latency", cyc, e.cyc);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap, output int c);
    int w;
    for (int i = 0; i < gap; i++) begin
      @(negedge clock);
      bus.in_valid = 1'b0;
    end
    @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 16) begin
      @(negedge clock);
      w++;
    end
    if (bus.in_ready !== 1'b1) begin
      check("send_ready", {31'b0, bus.in_ready}, 32'd1);
      bus.in_valid = 1'b0;
      c = -1;
    end else begin
      c = cyc;
      @(posedge clock);
      #1 bus.in_valid = 1'b0;
    end
  endtask

  task automatic pulse_reload();
    @(negedge clock);
    reload = 1'b1;
    @(negedge clock);
    reload = 1'b0;
  endtask

  task automatic run_frame(input int n, input bit bad, input int gapmax, input int reload_at);
    logic [7:0]  xs;
    logic [7:0]  b;
    logic [31:0] nv;
    int          c;
    nv = n;
    wr_count = 0;
    xs = 8'h00;
    b = nv[7:0];
    send_byte(b, 0, c);
    xs ^= b;
    b = nv[15:8];
    send_byte(b, 0, c);
    xs ^= b;
    for (int w = 0; w < n; w++) begin
      if (w == reload_at) pulse_reload();
      for (int k = 0; k < 4; k++) begin
        b = words[w][8*k +: 8];
        send_byte(b, $urandom_range(0, gapmax), c);
        xs ^= b;
        if (k == 3 && c >= 0) exp_q.push_back('{addr: 6'(w), data: words[w], cyc: c + 1});
      end
    end
    b = bad ? (xs ^ 8'h01) : xs;
    send_byte(b, 0, c);
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle_after_reload(input string tag);
    check({tag, "_rl_cpu_reset"}, {31'b0, cpu_reset}, 32'd1);
    check({tag, "_rl_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
    check({tag, "_rl_done"}, {31'b0, done}, 32'd0);
    check({tag, "_rl_error"}, {31'b0, error}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int c;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (2) @(negedge clock);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_imem_we", {31'b0, bus.imem_we}, 32'd0);
    check("rst_imem_addr", {26'b0, bus.imem_addr}, 32'd0);
    check("rst_imem_wdata", bus.imem_wdata, 32'd0);
    check("rst_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_error", {31'b0, error}, 32'd0);
    reset = 1'b0;

    //         n  fixed bad gap done err writes
    vecs[0] = '{1,  1'b1, 1'b0, 0, 1'b1, 1'b0, 1};
    vecs[1] = '{3,  1'b0, 1'b0, 3, 1'b1, 1'b0, 3};
    vecs[2] = '{1,  1'b1, 1'b1, 0, 1'b0, 1'b1, 1};
    vecs[3] = '{0,  1'b0, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[4] = '{64, 1'b0, 1'b0, 1, 1'b1, 1'b0, 64};

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 64; i++) words[i] = vecs[v].fixed ? 32'hCB120210 : $urandom;
      run_frame(vecs[v].n, vecs[v].bad, vecs[v].gapmax, -1);
      check($sformatf("v%0d_done", v), {31'b0, done}, {31'b0, vecs[v].exp_done});
      check($sformatf("v%0d_error", v), {31'b0, error}, {31'b0, vecs[v].exp_error});
      check($sformatf("v%0d_cpu_reset", v), {31'b0, cpu_reset}, {31'b0, !vecs[v].exp_done});
      check($sformatf("v%0d_in_ready", v), {31'b0, bus.in_ready}, 32'd0);
      check($sformatf("v%0d_writes", v), wr_count, vecs[v].exp_writes);
      check($sformatf("v%0d_sb_empty", v), exp_q.size(), 32'd0);
      pulse_reload();
      check_idle_after_reload($sformatf("v%0d", v));
    end

    // Count 65 exceeds the 64-word memory: error right after the count, no writes.
    wr_count = 0;
    send_byte(8'h41, 0, c);
    send_byte(8'h00, 0, c);
    @(negedge clock);
    check("ovf_error", {31'b0, error}, 32'd1);
    check("ovf_in_ready", {31'b0, bus.in_ready}, 32'd0);
    check("ovf_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    repeat (3) @(negedge clock);
    check("ovf_writes", wr_count, 32'd0);
    pulse_reload();
    check_idle_after_reload("ovf");
    words[0] = $urandom;
    run_frame(1, 1'b0, 0, -1);
    check("ovf_next_done", {31'b0, done}, 32'd1);
    check("ovf_next_writes", wr_count, 32'd1);
    pulse_reload();

    // Reset after two word bytes abandons the frame without writing.
    wr_count = 0;
    send_byte(8'h01, 0, c);
    send_byte(8'h00, 0, c);
    send_byte(8'h11, 0, c);
    send_byte(8'h22, 0, c);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check("mid_writes", wr_count, 32'd0);
    check("mid_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("mid_cpu_reset", {31'b0, cpu_reset}, 32'd1);
    check("mid_done", {31'b0, done}, 32'd0);

    // Following frame loads from address 0; a reload pulse mid-frame must be ignored.
    words[0] = $urandom;
    words[1] = $urandom;
    run_frame(2, 1'b0, 1, 1);
    check("mid_next_done", {31'b0, done}, 32'd1);
    check("mid_next_error", {31'b0, error}, 32'd0);
    check("mid_next_writes", wr_count, 32'd2);
    check("mid_next_sb_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
